// File: rtl/rgb_pio_pkg.sv
// Shared state encoding and PIO register-map bit positions for the RGB pixel sequencer.
package rgb_pio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } seq_state_t;

   localparam int CTRL_REQ   = 0;
   localparam int CTRL_SOF   = 1;
   localparam int CTRL_FLUSH = 2;
   localparam int CTRL_EN    = 3;

   localparam int ST_ACK     = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_LVL_LSB = 4;
   localparam int ST_CNT_LSB = 9;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO: a push is visible at dout one cycle later.
// Pushes while full and pops while empty are ignored; clear empties it in one cycle.
module pixel_fifo #(
   parameter int WIDTH   = 25,
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               clear,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LEVEL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      level <= level + LEVEL_W'(1);
         else if (!do_push && do_pop) level <= level - LEVEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rgb_pio_sequencer.sv
// Turns toggle-handshaked Nios RGB PIO writes into a FIFO-buffered pixel stream; push and ack land one cycle after the request.
// Sink back-pressure via pix_ready; a full FIFO parks the request in HOLD until a slot frees.
module rgb_pio_sequencer
   import rgb_pio_pkg::*;
#(
   parameter int COLOR_W    = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int LEVEL_W    = 5,
   parameter int CNT_W      = 9
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [COLOR_W-1:0]   pio_red,
   input  logic [COLOR_W-1:0]   pio_green,
   input  logic [COLOR_W-1:0]   pio_blue,
   input  logic [17:0]          pio_ctrl,
   output logic [17:0]          pio_status,
   output logic [3*COLOR_W-1:0] pix_data,
   output logic                 pix_sof,
   output logic                 pix_valid,
   input  logic                 pix_ready
);
   localparam int PIX_W = 3 * COLOR_W;

   seq_state_t         state;
   seq_state_t         state_nxt;
   logic               req_seen;
   logic               ovf;
   logic [CNT_W-1:0]   pix_cnt;
   logic               evt;
   logic               flush;
   logic               push;
   logic               pop;
   logic               clear;
   logic               take_req;
   logic               set_ovf;
   logic               full;
   logic               empty;
   logic [LEVEL_W-1:0] level;
   logic [PIX_W:0]     head;
   logic               unused_ctrl;

   assign evt         = pio_ctrl[CTRL_REQ] ^ req_seen;
   assign flush       = pio_ctrl[CTRL_FLUSH];
   assign unused_ctrl = ^pio_ctrl[17:4];

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (flush) state_nxt = FLUSH;
                  else if (evt && full) state_nxt = HOLD;
         HOLD:    if (flush) state_nxt = FLUSH;
                  else if (!full) state_nxt = IDLE;
         FLUSH:   if (!flush) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Full comes from the registered level, so a same-cycle pop cannot unblock a push.
   always_comb begin
      push     = 1'b0;
      set_ovf  = 1'b0;
      take_req = 1'b0;
      clear    = flush;
      unique case (state)
         IDLE: begin
            push    = !flush && evt && !full;
            set_ovf = !flush && evt && full;
         end
         HOLD:    push = !flush && !full;
         FLUSH: begin
            clear    = 1'b1;
            take_req = 1'b1;
         end
         default: clear = 1'b1;
      endcase
      if (push) take_req = 1'b1;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         req_seen <= 1'b0;
         ovf      <= 1'b0;
         pix_cnt  <= '0;
      end else begin
         if (take_req) req_seen <= pio_ctrl[CTRL_REQ];
         if (clear) begin
            ovf     <= 1'b0;
            pix_cnt <= '0;
         end else begin
            if (set_ovf) ovf <= 1'b1;
            if (pop)     pix_cnt <= pix_cnt + CNT_W'(1);
         end
      end
   end

   pixel_fifo #(
      .WIDTH   (PIX_W + 1),
      .DEPTH   (FIFO_DEPTH),
      .LEVEL_W (LEVEL_W)
   ) u_fifo (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .din   ({pio_ctrl[CTRL_SOF], pio_red, pio_green, pio_blue}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign pix_valid = !empty && pio_ctrl[CTRL_EN] && (state != FLUSH);
   assign pop       = pix_valid && pix_ready;
   // Unwritten RAM words must not leak out, so the head is masked while empty.
   assign pix_data  = empty ? '0 : head[PIX_W-1:0];
   assign pix_sof   = !empty && head[PIX_W];

   always_comb begin
      pio_status                          = '0;
      pio_status[ST_ACK]                  = req_seen;
      pio_status[ST_FULL]                 = full;
      pio_status[ST_EMPTY]                = empty;
      pio_status[ST_OVF]                  = ovf;
      pio_status[ST_LVL_LSB +: LEVEL_W]   = level;
      pio_status[ST_CNT_LSB +: CNT_W]     = pix_cnt;
   end

endmodule

// File: tb/tb_rgb_pio_sequencer.sv
// Directed bench for rgb_pio_sequencer: queued expected pixels are checked by a negedge monitor.
module tb_rgb_pio_sequencer;
   import rgb_pio_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  red, green, blue;
   logic [17:0] ctrl;
   logic [17:0] status;
   logic [23:0] pix_data;
   logic        pix_sof, pix_valid, pix_ready;

   logic [24:0] sb [$];
   logic [24:0] popped;
   int          n_pass  = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   rgb_pio_sequencer dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .pio_red       (red),
      .pio_green     (green),
      .pio_blue      (blue),
      .pio_ctrl      (ctrl),
      .pio_status    (status),
      .pix_data      (pix_data),
      .pix_sof       (pix_sof),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [17:0] st(input bit ack, input bit full, input bit empty,
                                      input bit ovf, input int lvl, input int cnt);
      logic [4:0] l;
      logic [8:0] c;
      l = lvl[4:0];
      c = cnt[8:0];
      return {c, l, ovf, empty, full, ack};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input bit sof, input bit accept);
      red   = r;
      green = g;
      blue  = b;
      ctrl[CTRL_SOF] = sof;
      ctrl[CTRL_REQ] = ~ctrl[CTRL_REQ];
      if (accept) sb.push_back({sof, r, g, b});
      tick();
   endtask

   // Head must always equal the oldest expected pixel; it is retired only on a handshake.
   always @(negedge clk) begin
      if (rst_n && pix_valid) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pixel: got 0x%0h expected none", {pix_sof, pix_data});
         end else begin
            chk("pixel_head", {7'b0, pix_sof, pix_data}, {7'b0, sb[0]});
            if (pix_ready) popped = sb.pop_front();
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ctrl = '0;
      red = '0; green = '0; blue = '0;
      pix_ready = 1'b0;
      tick();
      tick();
      chk("reset_status", status, st(0, 0, 1, 0, 0, 0));
      chk("reset_valid", pix_valid, 0);
      chk("reset_data", {pix_sof, pix_data}, 0);
      rst_n = 1'b1;
      tick();

      // single pixel, ctrl = 0x00B
      ctrl[CTRL_EN] = 1'b1;
      push_px(8'h12, 8'h34, 8'h56, 1, 1);
      chk("single_status", status, st(1, 0, 0, 0, 1, 0));
      chk("single_valid", pix_valid, 1);
      chk("single_data", {pix_sof, pix_data}, 25'h1123456);
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      chk("single_drained", status, st(1, 0, 1, 0, 0, 1));

      // fill to 16, then overflow into HOLD
      ctrl[CTRL_EN] = 1'b0;
      for (int i = 0; i < 16; i++)
         push_px(8'(i), 8'(i + 'h40), 8'(i + 'h80), i == 0, 1);
      chk("full_status", status, st(1, 1, 0, 0, 16, 1));
      push_px(8'hAA, 8'hBB, 8'hCC, 0, 1);
      chk("hold_status", status, st(1, 1, 0, 1, 16, 1));
      ctrl[CTRL_EN] = 1'b1;
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      chk("hold_after_pop", status, st(1, 0, 0, 1, 15, 2));
      tick();
      chk("hold_released", status, st(0, 1, 0, 1, 16, 2));

      // flush while a request is parked in HOLD
      push_px(8'hDD, 8'hEE, 8'hFF, 0, 0);
      chk("hold_pending", status, st(0, 1, 0, 1, 16, 2));
      ctrl[CTRL_FLUSH] = 1'b1;
      tick();
      sb.delete();
      chk("flush_cleared", status, st(0, 0, 1, 0, 0, 0));
      chk("flush_valid", pix_valid, 0);
      tick();
      chk("flush_ack", status, st(1, 0, 1, 0, 0, 0));
      ctrl[CTRL_FLUSH] = 1'b0;
      tick();
      push_px(8'h11, 8'h22, 8'h33, 1, 1);
      chk("post_flush_push", status, st(0, 0, 0, 0, 1, 0));
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      chk("post_flush_drain", status, st(0, 0, 1, 0, 0, 1));

      // enable gating and back-pressure
      ctrl[CTRL_EN] = 1'b0;
      push_px(8'h01, 8'h02, 8'h03, 1, 1);
      push_px(8'h04, 8'h05, 8'h06, 0, 1);
      push_px(8'h07, 8'h08, 8'h09, 0, 1);
      chk("gated_valid", pix_valid, 0);
      chk("gated_status", status, st(1, 0, 0, 0, 3, 1));
      ctrl[CTRL_EN] = 1'b1;
      pix_ready = 1'b1; tick();
      pix_ready = 1'b0; tick();
      chk("held_data", {pix_sof, pix_data}, 25'h0040506);
      pix_ready = 1'b1; tick();
      tick();
      pix_ready = 1'b0;
      chk("gated_drained", status, st(1, 0, 1, 0, 0, 4));
      chk("gated_sb_empty", sb.size(), 0);

      // count wrap: clear count, then 512 streamed pixels
      ctrl[CTRL_FLUSH] = 1'b1;
      tick();
      ctrl[CTRL_FLUSH] = 1'b0;
      tick();
      chk("wrap_start", status, st(1, 0, 1, 0, 0, 0));
      pix_ready = 1'b1;
      for (int i = 0; i < 512; i++)
         push_px(8'(i), 8'(~i), 8'(i >> 1), 0, 1);
      chk("count_511", status, st(1, 0, 0, 0, 1, 511));
      tick();
      pix_ready = 1'b0;
      chk("count_wrapped", status, st(1, 0, 1, 0, 0, 0));

      // reset with pixels buffered
      ctrl[CTRL_EN] = 1'b0;
      for (int i = 0; i < 4; i++)
         push_px(8'(i + 'h20), 8'h00, 8'hFF, 0, 1);
      chk("pre_reset_status", status, st(1, 0, 0, 0, 4, 0));
      rst_n = 1'b0;
      ctrl = '0;
      tick();
      sb.delete();
      chk("midreset_status", status, st(0, 0, 1, 0, 0, 0));
      chk("midreset_valid", pix_valid, 0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_reset_idle", status, st(0, 0, 1, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rgb_pio_sequencer.md
Name: rgb_pio_sequencer

Overview:
- Converts the Nios RGB/switch PIO register writes into a buffered 24-bit pixel stream with valid/ready handshake.
- Nios writes a pixel on the red/green/blue out ports, then flips a request-toggle bit on the 18-bit control out port. The block acknowledges by toggle and buffers the pixel in a 16-entry FIFO.
- The block drains the FIFO to the pixel sink and reports FIFO and count status back on the 18-bit control in port.

Parameters:
- COLOR_W, 8, bits per colour channel; pixel width is 3*COLOR_W.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two.
- LEVEL_W, 5, FIFO level width; equals log2(FIFO_DEPTH)+1.
- CNT_W, 9, drained-pixel counter width.

Ports:
- clk_clk  in  1  system clock, shared with Nios.
- reset_reset_n  in  1  synchronous active-low reset.
- pio_red  in  COLOR_W  from red_out_port.
- pio_green  in  COLOR_W  from green_out_port.
- pio_blue  in  COLOR_W  from blue_out_port.
- pio_ctrl  in  18  from sw_out_port:
  - [0] req toggle
  - [1] sof flag for this pixel
  - [2] flush, level-sensitive
  - [3] stream enable
  - [17:4] reserved, ignored
- pio_status  out  18  to sw_in_port:
  - [0] ack toggle
  - [1] full
  - [2] empty
  - [3] overflow (sticky)
  - [8:4] level
  - [17:9] pixel count
- pix_data  out  3*COLOR_W  {red, green, blue} of the FIFO head.
- pix_sof  out  1  sof flag stored with the head pixel.
- pix_valid  out  1  head pixel valid.
- pix_ready  in  1  sink accepts the head pixel.

Behaviour:
- Reset (reset_reset_n=0 at a clock edge):
  - FIFO emptied; state IDLE.
  - req_seen=0, so ack=0.
  - overflow=0, count=0.
  - pix_valid=0, pix_data=0, pix_sof=0.
  - A reset mid-operation discards all buffered pixels and any pending request.
- Request detect: event = pio_ctrl[0] != req_seen. ack output is req_seen.
- FSM states: IDLE, HOLD, FLUSH.
  - IDLE:
    - event and !full: push {sof, r, g, b} this cycle; req_seen <= pio_ctrl[0].
    - event and full: go to HOLD; overflow <= 1; req_seen unchanged.
    - pio_ctrl[2]=1: go to FLUSH. This has priority over everything else.
  - HOLD:
    - Each cycle, if !full: push the current PIO values, update req_seen, go to IDLE.
    - Nios must keep the PIO values stable until ack matches req.
  - FLUSH:
    - FIFO cleared; overflow=0; count=0; pix_valid=0.
    - Any event is acknowledged (req_seen <= pio_ctrl[0]) and the pixel discarded.
    - pio_ctrl[2]=0: go to IDLE.
- Push latency: pushed pixel is visible at the FIFO head and ack flips on the next cycle, i.e. one cycle after the event.
- Full is evaluated from the registered level before pop. A push is blocked when full even if a pop occurs in the same cycle, so HOLD persists one extra cycle.
- Drain:
  - pix_valid = !empty && pio_ctrl[3] && state!=FLUSH.
  - Pop when pix_valid && pix_ready.
  - pix_data and pix_sof reflect the head, show-ahead, and are stable while valid && !ready.
- Simultaneous push and pop when not full: level unchanged; ordering preserved.
- Enable=0: draining stops; pushes are still accepted.
- count: increments on each pop and wraps from 2^CNT_W-1 to 0. Cleared only by reset or FLUSH.
- overflow: set on IDLE to HOLD; cleared only by reset or FLUSH.
- pio_status is registered: fields reflect state after the previous edge.

Decomposition:
- Package rgb_pio_pkg holds:
  - the state enum (IDLE, HOLD, FLUSH);
  - ctrl bit index constants (CTRL_REQ=0, CTRL_SOF=1, CTRL_FLUSH=2, CTRL_EN=3);
  - status field offsets (ST_ACK=0, ST_FULL=1, ST_EMPTY=2, ST_OVF=3, ST_LVL_LSB=4, ST_CNT_LSB=9).
- Sub-module pixel_fifo:
  - synchronous show-ahead FIFO, width 3*COLOR_W+1, depth FIFO_DEPTH;
  - ports: push, pop, clear, full, empty, level.

Test Plan:
- Reset values: hold reset_reset_n=0 for 2 cycles -> pio_status=0x00004 (empty=1, all else 0), pix_valid=0.
- Single pixel: rgb=0x12/0x34/0x56, ctrl=0x00B (en, sof, req=1) -> next cycle ack=1, level=1, pix_valid=1, pix_data=0x123456, pix_sof=1. Then ready=1 for 1 cycle -> empty=1, count=1.
- Full and hold: en=0, 16 toggled pushes -> full=1, level=16. 17th toggle -> HOLD, overflow=1, ack unchanged. Then en=1 with ready=1 for 1 cycle -> next cycle push; ack matches req; level=16.
- Flush mid-HOLD: ctrl[2]=1 with a request pending -> ack follows req, level=0, overflow=0, count=0, pix_valid=0. Deassert flush -> IDLE; a new push works.
- Enable gating and back-pressure: 3 pixels queued, en=0 -> pix_valid=0. Set en=1 and ready toggling 1,0,1,1 -> 3 pixels out in push order, data held while ready=0.
- Count wrap and reset mid-stream: 512 pops -> count=0. Then 4 queued pixels and reset pulsed -> empty=1, ack=0, count=0.
